multi_clinic_numerator: RTL

Parametrised ticket numerator for NUM_CLINICS independent clinic queues. Each clinic owns a disjoint, contiguous block of ticket numbers that it issues and calls in circular order. Separate issue and call request channels can act in the same cycle, on the same or different clinics. The block sits between the ticket-printer front end and the announcement display, and replaces the fixed two-clinic numerator.

---
 rtl/multi_clinic_pkg.sv | 32 +++
 rtl/clinic_queue_ctr.sv | 80 ++++++++
 rtl/multi_clinic_numerator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/multi_clinic_pkg.sv
// ---------------------------------------------------------------------------
// multi_clinic_pkg : shared helpers for the multi-clinic ticket numerator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multi_clinic_pkg;

  typedef enum logic {
    ISSUE = 1'b0,
    CALL  = 1'b1
  } opcode_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int slots);
    return $clog2(slots + 1);
  endfunction

  function automatic int lo_limit(input int base, input int slots, input int c);
    return base + c * slots;
  endfunction

  function automatic int hi_limit(input int base, input int slots, input int c);
    return base + c * slots + slots - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clinic_queue_ctr.sv
// ---------------------------------------------------------------------------
// clinic_queue_ctr : head/tail/occupancy tracker for one clinic ticket range
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clinic_queue_ctr
  import multi_clinic_pkg::*;
#(
  parameter int             W     = 8,
  parameter int             SLOTS = 5,
  parameter int             CNTW  = 3,
  parameter logic [W-1:0]   LO    = '0,
  parameter logic [W-1:0]   HI    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_en_i,
  input  logic            call_en_i,
  output logic [W-1:0]    head_o,
  output logic [W-1:0]    tail_o,
  output logic [CNTW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            iss_ok_o,
  output logic            call_ok_o
);

  localparam logic [CNTW-1:0] SLOTS_C = CNTW'(SLOTS);

  logic [W-1:0]    head_q, head_d;
  logic [W-1:0]    tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;

  // Acceptance always looks at pre-edge occupancy: no bypass, no pass-through.
  assign iss_ok_o  = iss_en_i  && (count_q != SLOTS_C);
  assign call_ok_o = call_en_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (iss_ok_o)  tail_d = (tail_q == HI) ? LO : tail_q + 1'b1;
    if (call_ok_o) head_d = (head_q == HI) ? LO : head_q + 1'b1;
    case ({iss_ok_o, call_ok_o})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == SLOTS_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= LO;
      tail_q  <= LO;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

`default_nettype wire

// File: rtl/multi_clinic_numerator.sv
// ---------------------------------------------------------------------------
// multi_clinic_numerator : circular ticket issue/call for NUM_CLINICS queues
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_clinic_numerator
  import multi_clinic_pkg::*;
#(
  parameter int NUM_CLINICS = 4,
  parameter int SLOTS       = 5,
  parameter int BASE        = 5,
  parameter int W           = 8,
  localparam int CW         = sel_width(NUM_CLINICS),
  localparam int CNTW       = cnt_width(SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iss_req,
  input  logic [CW-1:0]          iss_sel,
  input  logic                   call_req,
  input  logic [CW-1:0]          call_sel,
  output logic                   iss_ack,
  output logic                   iss_nack,
  output logic [W-1:0]           iss_ticket,
  output logic                   call_ack,
  output logic                   call_nack,
  output logic [W-1:0]           call_ticket,
  output logic [NUM_CLINICS-1:0] empty,
  output logic [NUM_CLINICS-1:0] full,
  input  logic [CW-1:0]          mon_sel,
  output logic [CNTW-1:0]        mon_count
);

  localparam logic [CW:0] NC_C = (CW+1)'(NUM_CLINICS);

  if ((longint'(BASE) + longint'(NUM_CLINICS) * longint'(SLOTS) - 1) >= (longint'(1) << W))
  begin : g_param_check
    $error("multi_clinic_numerator: ticket range does not fit in W bits");
  end

  logic                   w_iss_in_range, w_call_in_range;
  logic [NUM_CLINICS-1:0] w_iss_en, w_call_en, w_iss_ok, w_call_ok;
  logic [W-1:0]           w_head  [NUM_CLINICS];
  logic [W-1:0]           w_tail  [NUM_CLINICS];
  logic [CNTW-1:0]        w_count [NUM_CLINICS];
  logic                   w_iss_acc, w_call_acc;
  logic [W-1:0]           w_iss_tkt, w_call_tkt;

  logic         iss_ack_q, iss_nack_q, call_ack_q, call_nack_q;
  logic [W-1:0] iss_ticket_q, call_ticket_q;

  assign w_iss_in_range  = ({1'b0, iss_sel}  < NC_C);
  assign w_call_in_range = ({1'b0, call_sel} < NC_C);

  for (genvar c = 0; c < NUM_CLINICS; c++) begin : g_clinic
    localparam logic [W-1:0] LO_C = W'(lo_limit(BASE, SLOTS, c));
    localparam logic [W-1:0] HI_C = W'(hi_limit(BASE, SLOTS, c));

    assign w_iss_en[c]  = iss_req  && w_iss_in_range  && (iss_sel  == CW'(c));
    assign w_call_en[c] = call_req && w_call_in_range && (call_sel == CW'(c));

    clinic_queue_ctr #(
      .W     (W),
      .SLOTS (SLOTS),
      .CNTW  (CNTW),
      .LO    (LO_C),
      .HI    (HI_C)
    ) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_en_i  (w_iss_en[c]),
      .call_en_i (w_call_en[c]),
      .head_o    (w_head[c]),
      .tail_o    (w_tail[c]),
      .count_o   (w_count[c]),
      .empty_o   (empty[c]),
      .full_o    (full[c]),
      .iss_ok_o  (w_iss_ok[c]),
      .call_ok_o (w_call_ok[c])
    );
  end

  assign w_iss_acc  = |w_iss_ok;
  assign w_call_acc = |w_call_ok;

  // One-hot enables steer the ticket and monitor muxes without out-of-range indexing.
  always_comb begin
    w_iss_tkt  = '0;
    w_call_tkt = '0;
    mon_count  = '0;
    for (int c = 0; c < NUM_CLINICS; c++) begin
      if (w_iss_en[c])          w_iss_tkt  = w_tail[c];
      if (w_call_en[c])         w_call_tkt = w_head[c];
      if (mon_sel == CW'(c))    mon_count  = w_count[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_ack_q     <= 1'b0;
      iss_nack_q    <= 1'b0;
      call_ack_q    <= 1'b0;
      call_nack_q   <= 1'b0;
      iss_ticket_q  <= '0;
      call_ticket_q <= '0;
    end else begin
      iss_ack_q   <= w_iss_acc;
      iss_nack_q  <= iss_req && !w_iss_acc;
      call_ack_q  <= w_call_acc;
      call_nack_q <= call_req && !w_call_acc;
      if (w_iss_acc)  iss_ticket_q  <= w_iss_tkt;
      if (w_call_acc) call_ticket_q <= w_call_tkt;
    end
  end

  assign iss_ack     = iss_ack_q;
  assign iss_nack    = iss_nack_q;
  assign iss_ticket  = iss_ticket_q;
  assign call_ack    = call_ack_q;
  assign call_nack   = call_nack_q;
  assign call_ticket = call_ticket_q;

endmodule

`default_nettype wire
